// File: rtl/spu_result_aggregator.sv
// ---------------------------------------------------------------------------
// spu_result_aggregator
//   Collects windows of same-op SPU results and reports count, sum, min and
//   max for each window as a byte-serial frame on a valid/ready port.
//
//   Optional feature macro: AGG_CHECKSUM_EN
//     defined   -> 6-byte frame, B5 = XOR of B0..B4, agg_last on B5
//     undefined -> 5-byte frame, agg_last on B4, no checksum logic
//
// Ports
//   clk        in   1  clock, all state on posedge
//   reset      in   1  synchronous active-high reset
//   res_valid  in   1  upstream result valid
//   res_data   in   8  upstream result, unsigned
//   res_op     in   2  OpSel tag of res_data
//   res_ready  out  1  result accepted this cycle (combinational)
//   flush      in   1  close the current partial window
//   agg_valid  out  1  frame byte valid
//   agg_ready  in   1  downstream accepts frame byte
//   agg_byte   out  8  frame byte (registered)
//   agg_last   out  1  final byte of frame (registered)
// ---------------------------------------------------------------------------
module spu_result_aggregator #(
  parameter int unsigned WINDOW = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  input  logic [1:0]        res_op,
  output logic              res_ready,
  input  logic              flush,
  output logic              agg_valid,
  input  logic              agg_ready,
  output logic [7:0]        agg_byte,
  output logic              agg_last
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_EMIT  = 1'b1;

`ifdef AGG_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd5;
`else
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif

  localparam logic [5:0] WIN_CNT = 6'(WINDOW);

  logic [0:0]        r_state;
  logic [5:0]        r_count;
  logic [15:0]       r_sum;
  logic [DATA_W-1:0] r_min;
  logic [DATA_W-1:0] r_max;
  logic [1:0]        r_op;
  logic [2:0]        r_idx;
  logic              r_agg_valid;
  logic [7:0]        r_agg_byte;
  logic              r_agg_last;

  logic              w_op_conflict;
  logic              w_accept;
  logic              w_close;
  logic [5:0]        w_cnt_nxt;
  logic [15:0]       w_sum_nxt;
  logic [DATA_W-1:0] w_min_nxt;
  logic [DATA_W-1:0] w_max_nxt;
  logic [1:0]        w_op_nxt;
  logic [2:0]        w_idx_nxt;
  logic [7:0]        w_byte_nxt;

  // A sample tagged with a different op than the open window is refused;
  // it stays on the bus and opens the next window after the frame drains.
  assign w_op_conflict = (r_count != 6'd0) && (res_op != r_op);
  assign res_ready     = ~reset & (r_state == ST_ACCUM) & ~w_op_conflict;
  assign w_accept      = res_valid & res_ready;

  always_comb begin
    w_cnt_nxt = r_count;
    w_sum_nxt = r_sum;
    w_min_nxt = r_min;
    w_max_nxt = r_max;
    w_op_nxt  = r_op;
    if (w_accept) begin
      w_cnt_nxt = r_count + 6'd1;
      w_sum_nxt = r_sum + 16'(res_data);
      if (res_data < r_min) w_min_nxt = res_data;
      if (res_data > r_max) w_max_nxt = res_data;
      if (r_count == 6'd0)  w_op_nxt  = res_op;
    end
  end

  // Close on a filling accept, a refused op change, or a flush that has at
  // least one sample (including one accepted in this same cycle).
  assign w_close = (r_state == ST_ACCUM) &
                   ((w_accept & (w_cnt_nxt == WIN_CNT)) |
                    (res_valid & w_op_conflict) |
                    (flush & (w_cnt_nxt != 6'd0)));

  assign w_idx_nxt = r_idx + 3'd1;

  // Bytes after B0 are taken from the frozen accumulators while emitting.
  always_comb begin
    case (w_idx_nxt)
      3'd1:    w_byte_nxt = r_sum[15:8];
      3'd2:    w_byte_nxt = r_sum[7:0];
      3'd3:    w_byte_nxt = 8'(r_min);
      3'd4:    w_byte_nxt = 8'(r_max);
`ifdef AGG_CHECKSUM_EN
      3'd5:    w_byte_nxt = {r_op, r_count} ^ r_sum[15:8] ^ r_sum[7:0] ^
                            8'(r_min) ^ 8'(r_max);
`endif
      default: w_byte_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_ACCUM;
      r_count     <= '0;
      r_sum       <= '0;
      r_min       <= '1;
      r_max       <= '0;
      r_op        <= '0;
      r_idx       <= '0;
      r_agg_valid <= 1'b0;
      r_agg_byte  <= '0;
      r_agg_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          r_count <= w_cnt_nxt;
          r_sum   <= w_sum_nxt;
          r_min   <= w_min_nxt;
          r_max   <= w_max_nxt;
          r_op    <= w_op_nxt;
          if (w_close) begin
            r_state     <= ST_EMIT;
            r_idx       <= '0;
            r_agg_valid <= 1'b1;
            r_agg_byte  <= {w_op_nxt, w_cnt_nxt};
            r_agg_last  <= 1'b0;
          end
        end
        ST_EMIT: begin
          if (agg_ready) begin
            if (r_idx == LAST_IDX) begin
              r_state     <= ST_ACCUM;
              r_count     <= '0;
              r_sum       <= '0;
              r_min       <= '1;
              r_max       <= '0;
              r_op        <= '0;
              r_idx       <= '0;
              r_agg_valid <= 1'b0;
              r_agg_byte  <= '0;
              r_agg_last  <= 1'b0;
            end else begin
              r_idx      <= w_idx_nxt;
              r_agg_byte <= w_byte_nxt;
              r_agg_last <= (w_idx_nxt == LAST_IDX);
            end
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  assign agg_valid = r_agg_valid;
  assign agg_byte  = r_agg_byte;
  assign agg_last  = r_agg_last;

endmodule

// File: tb/tb_spu_result_aggregator.sv
// ---------------------------------------------------------------------------
// tb_spu_result_aggregator
//   Directed scenarios followed by random traffic. A reference model keeps
//   the open window as a queue of samples and, when it closes, builds the
//   expected frame with plain arithmetic into a byte queue.
// ---------------------------------------------------------------------------
module tb_spu_result_aggregator;

  localparam int unsigned WINDOW = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       res_valid;
  logic [7:0] res_data;
  logic [1:0] res_op;
  logic       res_ready;
  logic       flush;
  logic       agg_valid;
  logic       agg_ready;
  logic [7:0] agg_byte;
  logic       agg_last;

  spu_result_aggregator #(.WINDOW(WINDOW), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_op    (res_op),
    .res_ready (res_ready),
    .flush     (flush),
    .agg_valid (agg_valid),
    .agg_ready (agg_ready),
    .agg_byte  (agg_byte),
    .agg_last  (agg_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: open window samples and pending frame bytes.
  int         win_q[$];
  logic [1:0] win_op;
  logic [8:0] exp_q[$];   // {last, byte}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic build_frame();
    int sum = 0;
    int mn  = 255;
    int mx  = 0;
    logic [7:0] b[$];
    logic [7:0] x;
    foreach (win_q[i]) begin
      sum += win_q[i];
      if (win_q[i] < mn) mn = win_q[i];
      if (win_q[i] > mx) mx = win_q[i];
    end
    b.push_back({win_op, 6'(win_q.size())});
    b.push_back(8'(sum / 256));
    b.push_back(8'(sum % 256));
    b.push_back(8'(mn));
    b.push_back(8'(mx));
`ifdef AGG_CHECKSUM_EN
    x = 8'h00;
    foreach (b[i]) x ^= b[i];
    b.push_back(x);
`else
    x = 8'h00;
`endif
    foreach (b[i]) exp_q.push_back({(i == b.size() - 1) ? 1'b1 : 1'b0, b[i]});
    win_q.delete();
  endtask

  // One clock cycle: drive at negedge, compare, advance the model, then
  // let the posedge happen.
  task automatic cyc(input bit rst, input bit rv, input logic [7:0] d,
                     input logic [1:0] op, input bit fl, input bit ar);
    bit busy, rdy_m, acc, close;
    @(negedge clk);
    reset = rst; res_valid = rv; res_data = d; res_op = op;
    flush = fl; agg_ready = ar;
    #1;
    busy  = (exp_q.size() > 0);
    rdy_m = !rst && !busy && !(win_q.size() > 0 && op != win_op);
    check("res_ready", res_ready, rdy_m);
    check("agg_valid", agg_valid, busy);
    if (busy) begin
      check("agg_byte", agg_byte, exp_q[0][7:0]);
      check("agg_last", agg_last, exp_q[0][8]);
    end
    if (rst) begin
      win_q.delete();
      exp_q.delete();
    end else if (busy) begin
      if (ar) void'(exp_q.pop_front());
    end else begin
      acc = rv && rdy_m;
      if (acc) begin
        if (win_q.size() == 0) win_op = op;
        win_q.push_back(d);
      end
      close = (acc && win_q.size() == WINDOW) || (rv && !rdy_m) ||
              (fl && win_q.size() > 0);
      if (close) build_frame();
    end
  endtask

  task automatic idle(input int n, input bit ar);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 2'b00, 0, ar);
  endtask

  initial begin
    reset = 1; res_valid = 0; res_data = 0; res_op = 0; flush = 0; agg_ready = 1;
    win_op = 2'b00;
    cyc(1, 0, 8'h00, 2'b00, 0, 1);
    cyc(1, 1, 8'h12, 2'b01, 1, 1);
    #1;
    check("rst_agg_byte", agg_byte, 8'h00);
    check("rst_agg_last", agg_last, 1'b0);

    // Full window, op=01: 44,00,64,0A,28
    cyc(0, 1, 8'd10, 2'b01, 0, 1);
    cyc(0, 1, 8'd20, 2'b01, 0, 1);
    cyc(0, 1, 8'd30, 2'b01, 0, 1);
    cyc(0, 1, 8'd40, 2'b01, 0, 1);
    idle(8, 1);

    // Op change: 9/op11 refused until frame 02,00,0C,05,07 drains
    cyc(0, 1, 8'd5, 2'b00, 0, 1);
    cyc(0, 1, 8'd7, 2'b00, 0, 1);
    for (int i = 0; i < 9; i++) cyc(0, 1, 8'd9, 2'b11, 0, 1);
    cyc(0, 0, 8'h00, 2'b00, 1, 1);
    idle(8, 1);

    // Saturation: 4x FF op=10 -> 84,03,FC,FF,FF, with backpressure at B1
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'hFF, 2'b10, 0, 1);
    cyc(0, 0, 8'h00, 2'b00, 0, 1);
    idle(3, 0);
    cyc(0, 1, 8'h01, 2'b10, 0, 0);
    idle(8, 1);

    // Flush with empty window, then single 0x33 with flush
    cyc(0, 0, 8'h00, 2'b00, 1, 1);
    idle(2, 1);
    cyc(0, 1, 8'h33, 2'b00, 0, 1);
    cyc(0, 0, 8'h00, 2'b00, 1, 1);
    idle(8, 1);
    cyc(0, 1, 8'h44, 2'b01, 1, 1);   // flush coincident with first accept
    idle(8, 1);

    // Reset during B2, then 1,1,1,1 op=00
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h07, 2'b01, 0, 1);
    idle(2, 1);
    cyc(1, 0, 8'h00, 2'b00, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h01, 2'b00, 0, 1);
    idle(8, 1);

    // Random traffic
    begin
      logic [1:0] cur_op = 2'b00;
      logic [7:0] d;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 7) == 0) cur_op = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 5))
          0:       d = 8'hFF;
          1:       d = 8'h00;
          default: d = 8'($urandom_range(0, 255));
        endcase
        cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, d, cur_op,
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
      end
    end
    idle(10, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
